// File: rtl/hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_control_unit
// Purpose  : Load-use, branch and MDU interlocks plus stall/flush counters.
// Revision : 1.0
// ============================================================================
module hazard_control_unit #(
    parameter int MDU_LATENCY = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  IFID_RegRs,
    input  logic [4:0]  IFID_RegRt,
    input  logic        IFID_UsesRt,
    input  logic        IFID_IsBranch,
    input  logic        IFID_IsMDU,
    input  logic        IFID_ReadsHiLo,
    input  logic        IDEX_MemRead,
    input  logic        IDEX_RegWrite,
    input  logic        IDEX_MDUStart,
    input  logic [4:0]  IDEX_RegRd,
    input  logic        EXMEM_MemRead,
    input  logic [4:0]  EXMEM_RegRd,
    input  logic        BranchTaken,
    output logic        PCWrite,
    output logic        IFID_Write,
    output logic        IFID_Flush,
    output logic        IDEX_Bubble,
    output logic        MDU_Busy,
    output logic [15:0] StallCycles,
    output logic [15:0] FlushCount
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    localparam logic [5:0]  C_MDU_LOAD = 6'(MDU_LATENCY - 1);
    localparam logic [15:0] C_SAT      = 16'hFFFF;

    mdu_state_t  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic w_busy;
    logic w_load_use;
    logic w_branch;
    logic w_mdu;
    logic w_stall;
    logic w_flush;

    // Register 0 never produces a hazard; rt only matters when it is a source.
    function automatic logic f_hit(input logic [4:0] r, input logic [4:0] rs,
                                   input logic [4:0] rt, input logic uses_rt);
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    always_comb begin
        w_busy     = (state_q == BUSY);
        w_load_use = IDEX_MemRead &&
                     f_hit(IDEX_RegRd, IFID_RegRs, IFID_RegRt, IFID_UsesRt);
        w_branch   = IFID_IsBranch &&
                     ((IDEX_RegWrite && f_hit(IDEX_RegRd, IFID_RegRs, IFID_RegRt, IFID_UsesRt)) ||
                      (EXMEM_MemRead && f_hit(EXMEM_RegRd, IFID_RegRs, IFID_RegRt, IFID_UsesRt)));
        w_mdu      = (IFID_IsMDU || IFID_ReadsHiLo) && (w_busy || IDEX_MDUStart);
        w_stall    = !rst && (w_load_use || w_branch || w_mdu);
        // Branch outcome is meaningless while its operands are still in flight.
        w_flush    = !rst && !w_stall && BranchTaken;

        PCWrite     = !w_stall;
        IFID_Write  = !w_stall;
        IDEX_Bubble = w_stall;
        IFID_Flush  = w_flush;
        MDU_Busy    = w_busy && !rst;
        StallCycles = stall_cnt_q;
        FlushCount  = flush_cnt_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (IDEX_MDUStart) begin
                    state_d = BUSY;
                    cnt_d   = C_MDU_LOAD;
                end
            end
            BUSY: begin
                if (cnt_q == 6'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (w_stall && (stall_cnt_q != C_SAT)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        flush_cnt_d = flush_cnt_q;
        if (w_flush && (flush_cnt_q != C_SAT)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_control_unit
// Purpose  : Directed and random checks of hazard_control_unit vs a cycle model.
// Revision : 1.0
// ============================================================================
module tb_hazard_control_unit;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  IFID_RegRs, IFID_RegRt, IDEX_RegRd, EXMEM_RegRd;
    logic        IFID_UsesRt, IFID_IsBranch, IFID_IsMDU, IFID_ReadsHiLo;
    logic        IDEX_MemRead, IDEX_RegWrite, IDEX_MDUStart, EXMEM_MemRead;
    logic        BranchTaken;
    logic        PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, MDU_Busy;
    logic [15:0] StallCycles, FlushCount;

    hazard_control_unit #(.MDU_LATENCY(L)) dut (
        .clk(clk), .rst(rst),
        .IFID_RegRs(IFID_RegRs), .IFID_RegRt(IFID_RegRt),
        .IFID_UsesRt(IFID_UsesRt), .IFID_IsBranch(IFID_IsBranch),
        .IFID_IsMDU(IFID_IsMDU), .IFID_ReadsHiLo(IFID_ReadsHiLo),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_RegWrite(IDEX_RegWrite),
        .IDEX_MDUStart(IDEX_MDUStart), .IDEX_RegRd(IDEX_RegRd),
        .EXMEM_MemRead(EXMEM_MemRead), .EXMEM_RegRd(EXMEM_RegRd),
        .BranchTaken(BranchTaken),
        .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IFID_Flush(IFID_Flush),
        .IDEX_Bubble(IDEX_Bubble), .MDU_Busy(MDU_Busy),
        .StallCycles(StallCycles), .FlushCount(FlushCount)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    // Reference state: remaining busy cycles of the MDU and the two counters.
    int busy_left = 0;
    int m_stalls  = 0;
    int m_flushes = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [4:0] r);
        return (r != 0) && ((r == IFID_RegRs) || (IFID_UsesRt && r == IFID_RegRt));
    endfunction

    function automatic bit m_stall();
        bit lu, br, md;
        lu = IDEX_MemRead && hit(IDEX_RegRd);
        br = IFID_IsBranch && ((IDEX_RegWrite && hit(IDEX_RegRd)) ||
                               (EXMEM_MemRead && hit(EXMEM_RegRd)));
        md = (IFID_IsMDU || IFID_ReadsHiLo) && ((busy_left > 0) || IDEX_MDUStart);
        return !rst && (lu || br || md);
    endfunction

    // One clock cycle: check combinational outputs, step the model, check counters.
    task automatic tick();
        bit s, f;
        #1;
        s = m_stall();
        f = !rst && !s && BranchTaken;
        check_value("pcwrite",    PCWrite,     !s);
        check_value("ifid_write", IFID_Write,  !s);
        check_value("bubble",     IDEX_Bubble, s);
        check_value("flush",      IFID_Flush,  f);
        check_value("mdu_busy",   MDU_Busy,    (busy_left > 0) && !rst);
        @(posedge clk);
        if (rst) begin
            busy_left = 0; m_stalls = 0; m_flushes = 0;
        end else begin
            if (busy_left > 0) busy_left--;
            else if (IDEX_MDUStart) busy_left = L;
            if (s && m_stalls < 65535) m_stalls++;
            if (f && m_flushes < 65535) m_flushes++;
        end
        #1;
        check_value("stall_cycles", StallCycles, m_stalls);
        check_value("flush_count",  FlushCount,  m_flushes);
    endtask

    task automatic clear_inputs();
        IFID_RegRs = 0; IFID_RegRt = 0; IDEX_RegRd = 0; EXMEM_RegRd = 0;
        IFID_UsesRt = 0; IFID_IsBranch = 0; IFID_IsMDU = 0; IFID_ReadsHiLo = 0;
        IDEX_MemRead = 0; IDEX_RegWrite = 0; IDEX_MDUStart = 0; EXMEM_MemRead = 0;
        BranchTaken = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        // Hazardous inputs during reset must be overridden.
        IDEX_MemRead = 1; IDEX_RegRd = 3; IFID_RegRs = 3; BranchTaken = 1; IDEX_MDUStart = 1;
        #1;
        check_value("rst_pcwrite", PCWrite, 1);
        check_value("rst_flush",   IFID_Flush, 0);
        check_value("rst_bubble",  IDEX_Bubble, 0);
        tick();
        check_value("rst_busy", MDU_Busy, 0);
        check_value("rst_stall_cnt", StallCycles, 0);
        rst = 0;
        clear_inputs();
        tick();

        // Load-use
        IDEX_MemRead = 1; IDEX_RegRd = 8; IFID_RegRs = 8;
        #1;
        check_value("lu_pcwrite", PCWrite, 0);
        check_value("lu_bubble",  IDEX_Bubble, 1);
        tick();
        check_value("lu_stall_cnt", StallCycles, 1);

        // Register 0 and rt gating
        IDEX_RegRd = 0; IFID_RegRs = 0;
        #1; check_value("r0_nostall", PCWrite, 1);
        tick();
        IDEX_RegRd = 9; IFID_RegRt = 9; IFID_UsesRt = 0; IFID_RegRs = 1;
        #1; check_value("rt_gate_nostall", PCWrite, 1);
        tick();
        IFID_UsesRt = 1;
        #1; check_value("rt_stall", PCWrite, 0);
        tick();
        clear_inputs();

        // Branch
        IFID_IsBranch = 1; IDEX_RegWrite = 1; IDEX_RegRd = 5; IFID_RegRs = 5; BranchTaken = 1;
        #1;
        check_value("br_stall", IDEX_Bubble, 1);
        check_value("br_noflush", IFID_Flush, 0);
        tick();
        IDEX_RegRd = 6;
        #1; check_value("br_flush", IFID_Flush, 1);
        tick();
        check_value("br_flush_cnt", FlushCount, 1);
        clear_inputs();

        // MDU: start pulse, mfhi held in ID
        IFID_ReadsHiLo = 1; IDEX_MDUStart = 1;
        #1; check_value("mdu_start_stall", PCWrite, 0);
        tick();
        IDEX_MDUStart = 0;
        for (int k = 1; k <= L + 2; k++) begin
            #1;
            check_value("mdu_busy_win", MDU_Busy, (k <= L));
            check_value("mdu_mfhi_stall", PCWrite, (k > L));
            tick();
        end

        // Reset two cycles into a BUSY sequence
        IDEX_MDUStart = 1;
        tick();
        IDEX_MDUStart = 0;
        tick();
        rst = 1;
        #1; check_value("abort_busy", MDU_Busy, 0);
        tick();
        rst = 0;
        #1;
        check_value("abort_busy_after", MDU_Busy, 0);
        check_value("abort_stall_cnt", StallCycles, 0);
        check_value("abort_flush_cnt", FlushCount, 0);
        tick();
        clear_inputs();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 39) == 0);
            IFID_RegRs     = 5'($urandom_range(0, 3));
            IFID_RegRt     = 5'($urandom_range(0, 3));
            IDEX_RegRd     = 5'($urandom_range(0, 3));
            EXMEM_RegRd    = 5'($urandom_range(0, 3));
            IFID_UsesRt    = 1'($urandom);
            IFID_IsBranch  = 1'($urandom);
            IFID_IsMDU     = ($urandom_range(0, 3) == 0);
            IFID_ReadsHiLo = ($urandom_range(0, 3) == 0);
            IDEX_MemRead   = 1'($urandom);
            IDEX_RegWrite  = 1'($urandom);
            IDEX_MDUStart  = ($urandom_range(0, 7) == 0);
            EXMEM_MemRead  = 1'($urandom);
            BranchTaken    = 1'($urandom);
            tick();
        end
        rst = 0;
        clear_inputs();

        // Saturation of the stall counter
        rst = 1;
        tick();
        rst = 0;
        IDEX_MemRead = 1; IDEX_RegRd = 8; IFID_RegRs = 8;
        for (int i = 0; i < 65540; i++) tick();
        check_value("stall_sat", StallCycles, 16'hFFFF);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
